// File: rtl/billiard_pkg.sv
// -----------------------------------------------------------------------------
// billiard_pkg
// Shared types and helpers for the billiard-table collision event logic.
//   evt_type_e       : kind of contact carried by an event
//   collision_evt_t  : one queued event {evt_type, id_a, id_b, aux}
//   num_pairs()      : number of unordered ball pairs for a given ball count
//   pair_index()     : dense index of pair (a,b), a<b, in the pair bitmap
// -----------------------------------------------------------------------------
package billiard_pkg;

    localparam int MAX_BALLS = 16;
    localparam int MAX_IDW   = 4;

    typedef enum logic [1:0] {
        EVT_NONE      = 2'd0,
        EVT_BALL_BALL = 2'd1,
        EVT_BALL_WALL = 2'd2,
        EVT_BALL_HOLE = 2'd3
    } evt_type_e;

    // IDs are stored at the widest supported width; narrower tables just
    // leave the upper bits at zero.
    typedef struct packed {
        evt_type_e            evt_type;
        logic [MAX_IDW-1:0]   id_a;
        logic [MAX_IDW-1:0]   id_b;
        logic [2:0]           aux;
    } collision_evt_t;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    localparam int NUM_PAIRS = num_pairs(MAX_BALLS);

    // Row-major packing of the upper triangle: all pairs starting with ball 0
    // come first, then those starting with ball 1, and so on.
    function automatic int pair_index(input int a, input int b, input int n);
        return a * (2 * n - a - 1) / 2 + (b - a - 1);
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Synchronous show-ahead FIFO of collision events.
// Ports:
//   clk, resetN     : clock, asynchronous active-low reset
//   flush           : synchronous clear of all entries
//   push, push_data : write request and event; accepted when not full, or when
//                     a pop happens in the same cycle
//   pop             : remove head; ignored while empty
//   head            : current head entry, all zeros while empty
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module evt_fifo
    import billiard_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic           flush,
    input  logic           push,
    input  collision_evt_t push_data,
    input  logic           pop,
    output collision_evt_t head,
    output logic           full,
    output logic           empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    collision_evt_t mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_pop;
    logic           do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a new entry when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage has no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/collision_event_queue.sv
// -----------------------------------------------------------------------------
// collision_event_queue
// Turns per-pixel draw-request overlaps during the raster scan into typed
// contact events (ball-ball, ball-wall, ball-hole), reported once per frame per
// pair/ball, and queues them for the physics logic.
// Ports:
//   clk, resetN        : clock, asynchronous active-low reset
//   startOfFrame       : frame-start pulse, forgets which contacts were reported
//   newGame            : restores all balls, flushes the queue, forgets contacts
//   Table_DR           : wall draw request, nonzero value is the wall code
//   Balls_DR_VEC       : per-ball draw requests
//   Hole_DR, Hole_ID   : hole draw request and the hole being drawn
//   evt_valid/evt_ready: head-of-queue handshake
//   evt_type/id_a/id_b/aux : head event fields, zero while the queue is empty
//   balls_in_game      : 1 = ball still on the table
//   collision          : an event entered the queue on the previous edge
//   overflow_cnt       : saturating count of events lost to a full queue
// -----------------------------------------------------------------------------
module collision_event_queue
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int IDW        = $clog2(NUM_BALLS)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 newGame,
    input  logic [1:0]           Table_DR,
    input  logic [NUM_BALLS-1:0] Balls_DR_VEC,
    input  logic                 Hole_DR,
    input  logic [2:0]           Hole_ID,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [1:0]           evt_type,
    output logic [IDW-1:0]       evt_id_a,
    output logic [IDW-1:0]       evt_id_b,
    output logic [2:0]           evt_aux,
    output logic [NUM_BALLS-1:0] balls_in_game,
    output logic                 collision,
    output logic [7:0]           overflow_cnt
);

    localparam int PAIRS = num_pairs(NUM_BALLS);
    localparam int PIW   = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    logic [NUM_BALLS-1:0] act;
    logic                 first_found;
    logic                 second_found;
    logic [IDW-1:0]       first_idx;
    logic [IDW-1:0]       second_idx;
    logic [PIW-1:0]       pair_idx;
    logic [NUM_BALLS-1:0] ball_onehot;
    logic [PAIRS-1:0]     pair_onehot;

    logic [PAIRS-1:0]     pair_seen;
    logic [NUM_BALLS-1:0] wall_seen;
    logic [PAIRS-1:0]     pair_seen_eff;
    logic [NUM_BALLS-1:0] wall_seen_eff;

    logic                 sel_hole;
    logic                 sel_bb;
    logic                 sel_wall;
    logic                 push_req;
    logic                 push_ok;
    logic                 drop;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    collision_evt_t       new_evt;
    collision_evt_t       head;

    // Balls already pocketed are invisible to every detector.
    assign act = Balls_DR_VEC & balls_in_game;

    // Lowest and second-lowest active balls; ball-ball contacts involving three
    // or more balls on one pixel are reported for the two lowest IDs.
    always_comb begin
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (act[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = IDW'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = IDW'(i);
                end
            end
        end
    end

    assign pair_idx    = PIW'(pair_index(int'(first_idx), int'(second_idx), NUM_BALLS));
    assign ball_onehot = NUM_BALLS'(1) << first_idx;
    assign pair_onehot = PAIRS'(1) << pair_idx;

    // A frame start wipes the seen-state before this cycle's detection looks
    // at it, so a contact on the very first pixel still counts for the new frame.
    assign pair_seen_eff = startOfFrame ? '0 : pair_seen;
    assign wall_seen_eff = startOfFrame ? '0 : wall_seen;

    // Priority among contacts that would actually produce an event:
    // hole, then unreported pair, then unreported wall touch. Losers are not
    // marked seen and get another chance on later pixels.
    always_comb begin
        sel_hole = Hole_DR && first_found;
        sel_bb   = !sel_hole && second_found && !(|(pair_seen_eff & pair_onehot));
        sel_wall = !sel_hole && !sel_bb && (Table_DR != 2'd0) && first_found
                   && !(|(wall_seen_eff & ball_onehot));
    end

    always_comb begin
        new_evt      = '0;
        new_evt.id_a = MAX_IDW'(first_idx);
        if (sel_hole) begin
            new_evt.evt_type = EVT_BALL_HOLE;
            new_evt.aux      = Hole_ID;
        end else if (sel_bb) begin
            new_evt.evt_type = EVT_BALL_BALL;
            new_evt.id_b     = MAX_IDW'(second_idx);
        end else if (sel_wall) begin
            new_evt.evt_type = EVT_BALL_WALL;
            new_evt.aux      = {1'b0, Table_DR};
        end else begin
            new_evt.id_a = '0;
        end
    end

    assign evt_valid = !fifo_empty;
    assign fifo_pop  = evt_valid && evt_ready;
    assign push_req  = !newGame && (sel_hole || sel_bb || sel_wall);
    assign push_ok   = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && fifo_full && !fifo_pop;

    evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .flush     (newGame),
        .push      (push_req),
        .push_data (new_evt),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_type = head.evt_type;
    assign evt_id_a = head.id_a[IDW-1:0];
    assign evt_id_b = head.id_b[IDW-1:0];
    assign evt_aux  = head.aux;

    // A pocketed ball leaves the game even when its event is dropped.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            balls_in_game <= '1;
        end else if (newGame) begin
            balls_in_game <= '1;
        end else if (sel_hole) begin
            balls_in_game <= balls_in_game & ~ball_onehot;
        end
    end

    // Seen bits are set for every selected contact, dropped or queued, so a
    // full queue never turns into a storm of repeated events.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pair_seen <= '0;
            wall_seen <= '0;
        end else if (newGame) begin
            pair_seen <= '0;
            wall_seen <= '0;
        end else begin
            pair_seen <= pair_seen_eff | (sel_bb   ? pair_onehot : '0);
            wall_seen <= wall_seen_eff | (sel_wall ? ball_onehot : '0);
        end
    end

    // The drop counter survives newGame so lost events stay visible across games.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overflow_cnt <= 8'd0;
            collision    <= 1'b0;
        end else begin
            collision <= push_ok;
            if (drop && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_collision_event_queue.sv
// -----------------------------------------------------------------------------
// tb_collision_event_queue
// Directed scenarios plus a randomized run for collision_event_queue, checked
// against a list-based reference model of the contact rules.
// -----------------------------------------------------------------------------
module tb_collision_event_queue;

    localparam int NB    = 16;
    localparam int DEPTH = 8;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        newGame;
    logic [1:0]  Table_DR;
    logic [15:0] Balls_DR_VEC;
    logic        Hole_DR;
    logic [2:0]  Hole_ID;
    logic        evt_ready;
    logic        evt_valid;
    logic [1:0]  evt_type;
    logic [3:0]  evt_id_a;
    logic [3:0]  evt_id_b;
    logic [2:0]  evt_aux;
    logic [15:0] balls_in_game;
    logic        collision;
    logic [7:0]  overflow_cnt;

    collision_event_queue #(
        .NUM_BALLS  (NB),
        .FIFO_DEPTH (DEPTH),
        .IDW        (4)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .newGame       (newGame),
        .Table_DR      (Table_DR),
        .Balls_DR_VEC  (Balls_DR_VEC),
        .Hole_DR       (Hole_DR),
        .Hole_ID       (Hole_ID),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_type      (evt_type),
        .evt_id_a      (evt_id_a),
        .evt_id_b      (evt_id_b),
        .evt_aux       (evt_aux),
        .balls_in_game (balls_in_game),
        .collision     (collision),
        .overflow_cnt  (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: events as plain records in a queue, seen-state as a
    // ball-by-ball matrix, balls as a flag array.
    typedef struct {
        int t;
        int a;
        int b;
        int aux;
    } ev_t;

    ev_t mq[$];
    bit  m_in_game[NB];
    bit  m_pair_seen[NB][NB];
    bit  m_wall_seen[NB];
    int  m_ovf;
    bit  m_coll;

    task automatic model_clear_seen();
        for (int i = 0; i < NB; i++) begin
            m_wall_seen[i] = 1'b0;
            for (int j = 0; j < NB; j++) m_pair_seen[i][j] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_in_game[i] = 1'b1;
        model_clear_seen();
        mq.delete();
        m_ovf  = 0;
        m_coll = 1'b0;
    endtask

    task automatic model_step();
        int  act[$];
        ev_t e;
        bit  have;
        have = 1'b0;
        e    = '{0, 0, 0, 0};
        if (newGame) begin
            for (int i = 0; i < NB; i++) m_in_game[i] = 1'b1;
            model_clear_seen();
            mq.delete();
            m_coll = 1'b0;
            return;
        end
        if (startOfFrame) model_clear_seen();
        for (int i = 0; i < NB; i++)
            if (Balls_DR_VEC[i] && m_in_game[i]) act.push_back(i);
        if (Hole_DR && act.size() > 0) begin
            e = '{3, act[0], 0, int'(Hole_ID)};
            have = 1'b1;
            m_in_game[act[0]] = 1'b0;
        end else if (act.size() >= 2 && !m_pair_seen[act[0]][act[1]]) begin
            e = '{1, act[0], act[1], 0};
            have = 1'b1;
            m_pair_seen[act[0]][act[1]] = 1'b1;
        end else if (Table_DR != 2'd0 && act.size() > 0 && !m_wall_seen[act[0]]) begin
            e = '{2, act[0], 0, int'(Table_DR)};
            have = 1'b1;
            m_wall_seen[act[0]] = 1'b1;
        end
        if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
        m_coll = 1'b0;
        if (have) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(e);
                m_coll = 1'b1;
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
    endtask

    // Advance one clock: the model consumes the inputs the DUT is about to sample.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        startOfFrame = 1'b0;
        newGame      = 1'b0;
        Table_DR     = 2'd0;
        Balls_DR_VEC = 16'h0000;
        Hole_DR      = 1'b0;
        Hole_ID      = 3'd0;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        resetN = 1'b0;
        drive_idle();
        evt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        got = {evt_type, evt_id_a, evt_id_b, evt_aux};
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", evt_valid);
        end
        checks++;
        if (got !== 13'd0) begin
            errors++; $display("[TB] FAIL reset_fields: got %0h expected 0", got);
        end
        checks++;
        if (balls_in_game !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL reset_balls: got %0h expected ffff", balls_in_game);
        end
        checks++;
        if (collision !== 1'b0 || overflow_cnt !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_coll_ovf: got %0b/%0d expected 0/0", collision, overflow_cnt);
        end
        @(negedge clk);
        resetN = 1'b1;
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_idle_valid: got %0b expected 0", evt_valid);
        end
    endtask

    task automatic test_ball_ball();
        int nev = 0;
        int npulse = 0;
        drive_idle();
        evt_ready = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        Balls_DR_VEC = 16'h0024;
        for (int k = 0; k < 23; k++) begin
            if (k == 20) Balls_DR_VEC = 16'h0000;
            tick();
            if (collision) npulse++;
            if (evt_valid) begin
                nev++;
                checks++;
                if ({evt_type, evt_id_a, evt_id_b, evt_aux} !== {2'd1, 4'd2, 4'd5, 3'd0}) begin
                    errors++;
                    $display("[TB] FAIL bb_fields: got %0d/%0d/%0d/%0d expected 1/2/5/0",
                             evt_type, evt_id_a, evt_id_b, evt_aux);
                end
            end
        end
        checks++;
        if (nev != 1) begin
            errors++; $display("[TB] FAIL bb_count: got %0d expected 1", nev);
        end
        checks++;
        if (npulse != 1) begin
            errors++; $display("[TB] FAIL bb_collision_pulses: got %0d expected 1", npulse);
        end
    endtask

    task automatic test_wall_frames();
        int nev = 0;
        drive_idle();
        evt_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            // frame 0: separate frame pulse; frame 1: pulse on the contact pixel
            if (f == 0) begin
                startOfFrame = 1'b1;
                tick();
                startOfFrame = 1'b0;
            end
            for (int k = 0; k < 8; k++) begin
                startOfFrame = (f == 1 && k == 0);
                Balls_DR_VEC = (k < 5) ? 16'h0008 : 16'h0000;
                Table_DR     = (k < 5) ? 2'd2 : 2'd0;
                tick();
                if (evt_valid) begin
                    nev++;
                    checks++;
                    if ({evt_type, evt_id_a, evt_id_b, evt_aux} !== {2'd2, 4'd3, 4'd0, 3'd2}) begin
                        errors++;
                        $display("[TB] FAIL wall_fields: got %0d/%0d/%0d/%0d expected 2/3/0/2",
                                 evt_type, evt_id_a, evt_id_b, evt_aux);
                    end
                end
            end
        end
        drive_idle();
        checks++;
        if (nev != 2) begin
            errors++; $display("[TB] FAIL wall_count: got %0d expected 2", nev);
        end
    endtask

    task automatic test_hole();
        int nev = 0;
        drive_idle();
        evt_ready = 1'b1;
        Balls_DR_VEC = 16'h0080;
        Hole_DR = 1'b1;
        Hole_ID = 3'd4;
        tick();
        checks++;
        if (evt_valid !== 1'b1 ||
            {evt_type, evt_id_a, evt_id_b, evt_aux} !== {2'd3, 4'd7, 4'd0, 3'd4}) begin
            errors++;
            $display("[TB] FAIL hole_fields: got v%0b %0d/%0d/%0d/%0d expected v1 3/7/0/4",
                     evt_valid, evt_type, evt_id_a, evt_id_b, evt_aux);
        end
        checks++;
        if (balls_in_game[7] !== 1'b0) begin
            errors++; $display("[TB] FAIL hole_ball_removed: got %0b expected 0", balls_in_game[7]);
        end
        Table_DR = 2'd1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (evt_valid) nev++;
        end
        drive_idle();
        checks++;
        if (nev != 0) begin
            errors++; $display("[TB] FAIL hole_ignored_ball: got %0d events expected 0", nev);
        end
    endtask

    task automatic test_same_pixel();
        drive_idle();
        evt_ready = 1'b0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        Balls_DR_VEC = 16'h0012;
        Table_DR = 2'd3;
        Hole_DR = 1'b1;
        Hole_ID = 3'd1;
        tick();
        Hole_DR = 1'b0;
        tick();
        drive_idle();
        checks++;
        if ({evt_valid, evt_type, evt_id_a, evt_id_b, evt_aux} !== {1'b1, 2'd3, 4'd1, 4'd0, 3'd1}) begin
            errors++;
            $display("[TB] FAIL same_pixel_first: got v%0b %0d/%0d/%0d/%0d expected v1 3/1/0/1",
                     evt_valid, evt_type, evt_id_a, evt_id_b, evt_aux);
        end
        evt_ready = 1'b1;
        tick();
        checks++;
        if ({evt_valid, evt_type, evt_id_a, evt_id_b, evt_aux} !== {1'b1, 2'd2, 4'd4, 4'd0, 3'd3}) begin
            errors++;
            $display("[TB] FAIL same_pixel_second: got v%0b %0d/%0d/%0d/%0d expected v1 2/4/0/3",
                     evt_valid, evt_type, evt_id_a, evt_id_b, evt_aux);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL same_pixel_drained: got %0b expected 0", evt_valid);
        end
    endtask

    task automatic test_overflow();
        int pa[10] = '{0, 2, 4, 6, 8, 10, 12, 14, 1, 3};
        int pb[10] = '{1, 3, 5, 7, 9, 11, 13, 15, 2, 4};
        drive_idle();
        evt_ready = 1'b1;
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        evt_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            Balls_DR_VEC = (16'(1) << pa[k]) | (16'(1) << pb[k]);
            tick();
        end
        drive_idle();
        checks++;
        if (overflow_cnt !== 8'd2) begin
            errors++; $display("[TB] FAIL ovf_count: got %0d expected 2", overflow_cnt);
        end
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({evt_valid, evt_type, evt_id_a, evt_id_b, evt_aux} !==
                {1'b1, 2'd1, 4'(pa[k]), 4'(pb[k]), 3'd0}) begin
                errors++;
                $display("[TB] FAIL ovf_drain_%0d: got v%0b %0d/%0d/%0d expected v1 1/%0d/%0d",
                         k, evt_valid, evt_type, evt_id_a, evt_id_b, pa[k], pb[k]);
            end
            tick();
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL ovf_drained: got %0b expected 0", evt_valid);
        end
    endtask

    task automatic queue_three();
        drive_idle();
        evt_ready = 1'b0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        Balls_DR_VEC = 16'h0003;
        tick();
        Balls_DR_VEC = 16'h0005;
        tick();
        Balls_DR_VEC = 16'h0200;
        Hole_DR = 1'b1;
        Hole_ID = 3'd6;
        tick();
        drive_idle();
    endtask

    task automatic test_reset_midframe();
        // synchronous clear through newGame; drop counter must survive
        queue_three();
        checks++;
        if (evt_valid !== 1'b1 || balls_in_game !== 16'hFDFF) begin
            errors++; $display("[TB] FAIL ng_setup: got v%0b balls %0h expected v1 fdff", evt_valid, balls_in_game);
        end
        newGame = 1'b1;
        tick();
        newGame = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || balls_in_game !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL ng_clear: got v%0b balls %0h expected v0 ffff", evt_valid, balls_in_game);
        end
        checks++;
        if (overflow_cnt !== 8'd2) begin
            errors++; $display("[TB] FAIL ng_ovf_kept: got %0d expected 2", overflow_cnt);
        end
        // asynchronous reset mid-cycle
        queue_three();
        #3;
        resetN = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || balls_in_game !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL async_reset: got v%0b balls %0h expected v0 ffff", evt_valid, balls_in_game);
        end
        checks++;
        if (overflow_cnt !== 8'd0) begin
            errors++; $display("[TB] FAIL async_reset_ovf: got %0d expected 0", overflow_cnt);
        end
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        evt_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [12:0] got;
        logic [12:0] exp_f;
        logic [15:0] exp_bin;
        bit          exp_v;
        int          r;
        bit          ready_mode;
        ready_mode = 1'b1;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (cyc % 30 == 0) ready_mode = ($urandom_range(0, 2) != 0);
            evt_ready    = ready_mode ? ($urandom_range(0, 3) != 0) : 1'b0;
            startOfFrame = (cyc % 37 == 0);
            newGame      = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 9);
            if (r < 3)      Balls_DR_VEC = 16'h0000;
            else if (r < 7) Balls_DR_VEC = 16'(1) << $urandom_range(0, 15);
            else            Balls_DR_VEC = (16'(1) << $urandom_range(0, 5)) | (16'(1) << $urandom_range(0, 5));
            Table_DR = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            Hole_DR  = ($urandom_range(0, 19) == 0);
            Hole_ID  = 3'($urandom_range(0, 7));
            tick();
            exp_v = (mq.size() > 0);
            exp_f = exp_v ? {2'(mq[0].t), 4'(mq[0].a), 4'(mq[0].b), 3'(mq[0].aux)} : 13'd0;
            for (int i = 0; i < NB; i++) exp_bin[i] = m_in_game[i];
            got = {evt_type, evt_id_a, evt_id_b, evt_aux};
            checks++;
            if (evt_valid !== exp_v || got !== exp_f) begin
                errors++;
                $display("[TB] FAIL rand_head@%0d: got v%0b %0h expected v%0b %0h", cyc, evt_valid, got, exp_v, exp_f);
            end
            checks++;
            if (balls_in_game !== exp_bin) begin
                errors++; $display("[TB] FAIL rand_balls@%0d: got %0h expected %0h", cyc, balls_in_game, exp_bin);
            end
            checks++;
            if (collision !== m_coll || overflow_cnt !== 8'(m_ovf)) begin
                errors++;
                $display("[TB] FAIL rand_coll_ovf@%0d: got %0b/%0d expected %0b/%0d",
                         cyc, collision, overflow_cnt, m_coll, m_ovf);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_ball_ball();
        test_wall_frames();
        test_hole();
        test_same_pixel();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
